// File: rtl/alu_arbiter_pkg.sv
// Shared ALUOp codes (mirroring ctrl_encode_def.v) and the arbiter FSM state encodings.
package alu_arbiter_pkg;

   localparam int ALUOP_W = 5;

   localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 5'h00;
   localparam logic [ALUOP_W-1:0] ALUOP_ADDU = 5'h01;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD  = 5'h02;
   localparam logic [ALUOP_W-1:0] ALUOP_SUBU = 5'h03;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB  = 5'h04;
   localparam logic [ALUOP_W-1:0] ALUOP_AND  = 5'h05;
   localparam logic [ALUOP_W-1:0] ALUOP_OR   = 5'h06;
   localparam logic [ALUOP_W-1:0] ALUOP_NOR  = 5'h07;
   localparam logic [ALUOP_W-1:0] ALUOP_XOR  = 5'h08;
   localparam logic [ALUOP_W-1:0] ALUOP_EQL  = 5'h0B;
   localparam logic [ALUOP_W-1:0] ALUOP_LUI  = 5'h14;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   // Ops the shared ALU is trusted to execute; anything else is answered with err.
   function automatic logic op_supported(input logic [ALUOP_W-1:0] op);
      case (op)
         ALUOP_ADDU, ALUOP_SUBU, ALUOP_OR, ALUOP_EQL,
         ALUOP_LUI, ALUOP_ADD, ALUOP_SUB: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin selector: the sole valid requester wins, a tie goes to
// whichever requester was not served last.
module rr_pick2 (
   input  logic valid0,
   input  logic valid1,
   input  logic last_owner,
   output logic grant,
   output logic winner
);

   assign grant  = valid0 | valid1;
   assign winner = (valid0 & valid1) ? ~last_owner : valid1;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: round-robin request
// acceptance, one registered EXEC cycle, then a held response per owner.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int              DW      = 32,
   parameter int              OPW     = 5,
   parameter logic [OPW-1:0]  IDLE_OP = OPW'(ALUOP_ADDU)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [OPW-1:0]  req0_op,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic [OPW-1:0]  req1_op,
   output logic            resp0_valid,
   input  logic            resp0_ready,
   output logic            resp1_valid,
   input  logic            resp1_ready,
   output logic [DW-1:0]   resp_data,
   output logic            resp_zero,
   output logic            resp_err,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [OPW-1:0]  alu_op,
   input  logic [DW-1:0]   alu_c,
   input  logic            alu_zero,
   output arb_state_t      arb_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready may depend on valid.

   arb_state_t      state_q, state_d;
   logic            owner_q, last_owner_q;
   logic [DW-1:0]   a_q, b_q, data_q;
   logic [OPW-1:0]  op_q;
   logic            zero_q, err_q;

   logic            grant, winner;
   logic [DW-1:0]   sel_a, sel_b;
   logic [OPW-1:0]  sel_op;
   logic            sel_supported;
   logic            accept;
   logic            resp_fire;

   rr_pick2 u_pick (
      .valid0     (req0_valid),
      .valid1     (req1_valid),
      .last_owner (last_owner_q),
      .grant      (grant),
      .winner     (winner)
   );

   assign sel_a         = winner ? req1_a  : req0_a;
   assign sel_b         = winner ? req1_b  : req0_b;
   assign sel_op        = winner ? req1_op : req0_op;
   assign sel_supported = op_supported(ALUOP_W'(sel_op));

   // rstn gates acceptance so both readies stay low while reset is held.
   assign accept    = rstn && (state_q == ARB_IDLE) && grant;
   assign resp_fire = (state_q == ARB_RESP) && (owner_q ? resp1_ready : resp0_ready);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (accept)    state_d = sel_supported ? ARB_EXEC : ARB_RESP;
         ARB_EXEC:                state_d = ARB_RESP;
         ARB_RESP: if (resp_fire) state_d = ARB_IDLE;
         default:                 state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      req0_ready  = accept && !winner;
      req1_ready  = accept &&  winner;
      resp0_valid = (state_q == ARB_RESP) && !owner_q;
      resp1_valid = (state_q == ARB_RESP) &&  owner_q;
      alu_op      = (state_q == ARB_EXEC) ? op_q : IDLE_OP;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= IDLE_OP;
         data_q       <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            owner_q <= winner;
            if (!sel_supported) begin
               data_q <= '0;
               zero_q <= 1'b0;
               err_q  <= 1'b1;
            end
         end
         // EQL reports only through zero; every other op reports only through data.
         if (state_q == ARB_EXEC) begin
            if (op_q == OPW'(ALUOP_EQL)) begin
               data_q <= '0;
               zero_q <= alu_zero;
            end else begin
               data_q <= alu_c;
               zero_q <= 1'b0;
            end
            err_q <= 1'b0;
         end
         if (resp_fire) begin
            last_owner_q <= owner_q;
         end
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign resp_data = data_q;
   assign resp_zero = zero_q;
   assign resp_err  = err_q;
   assign arb_state = state_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters, e.g. port 0 = execute stage, port 1 = branch-compare / address unit.
- Each requester issues {A, B, ALUOp} over a valid/ready handshake and gets {C, zero, err} back over a second valid/ready handshake.
- Round-robin arbitration; operands and result are registered, so the ALU sees stable inputs for one full cycle.

Parameters:
- DW, 32, operand/result width
- OPW, 5, ALUOp width (encodings from ctrl_encode_def.v)
- IDLE_OP, `ALUOp_ADDU, ALUOp driven onto the ALU when no operation is executing

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  DW  requester 0 operands
- req0_op  in  OPW  requester 0 ALUOp
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as port 0, for requester 1
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 consumes result
- resp1_valid  out  1  result for requester 1 available
- resp1_ready  in  1  requester 1 consumes result
- resp_data  out  DW  result C (shared, qualified by respN_valid)
- resp_zero  out  1  equality flag (shared)
- resp_err  out  1  unsupported ALUOp (shared)
- alu_a, alu_b  out  DW  to ALU A/B
- alu_op  out  OPW  to ALU ALUOp
- alu_c  in  DW  from ALU C
- alu_zero  in  1  from ALU zero

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (rstn=0, async) forces:
  - state=IDLE, owner=0, last_owner=1 (so req0 wins first)
  - operand regs 0, result regs 0, all ready/valid outputs 0
  - alu_op=IDLE_OP, alu_a=alu_b=0
- IDLE:
  - Winner: only-valid requester, or if both valid the one != last_owner.
  - reqN_ready=1 combinationally for the winner only; the other ready=0.
  - On handshake: latch a, b, op, owner.
  - Next state: EXEC if op is one of ADDU, SUBU, OR, EQL, LUI, ADD, SUB; otherwise RESP with err=1, data=0, zero=0.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_op driven from the latched regs; outside EXEC alu_op=IDLE_OP and alu_a/alu_b hold the latched values.
  - At the clock edge, capture the result:
    - EQL: data = 0, zero = alu_zero.
    - All other ops: data = alu_c, zero = 0.
    - err = 0.
  - Next state: RESP.
- RESP:
  - resp{owner}_valid=1, other valid=0; data/zero/err stable until the handshake.
  - On resp{owner}_ready=1: last_owner = owner, state=IDLE.
  - The non-owner's resp_ready is ignored.
- Latency:
  - Request handshake at edge N, result valid from the cycle after edge N+1.
  - With the consumer always ready, peak throughput is 1 op per 3 cycles.
- No request is accepted in EXEC or RESP (both readies 0).
- Requester changing a/b/op while valid and not ready: no effect; only values at the handshake are used.
- Back-to-back: if the same requester and the other are both waiting in IDLE after a RESP, the other wins (strict alternation under contention).
- Reset asserted mid-EXEC/RESP: operation dropped, no response, state as at reset.
- Response held indefinitely if resp_ready stays low (no timeout).

Decomposition:
- ALUOp codes stay in the shared ctrl_encode_def.v; add FSM state encodings (ARB_IDLE, ARB_EXEC, ARB_RESP) there.
- Optional sub-module rr_pick2: pure 2-way round-robin selector (valid0, valid1, last_owner -> grant, winner).
- The ALU itself is instantiated outside this block.

Test Plan:
- Single op: req0 {A=5, B=3, op=ADDU} -> req0_ready in the cycle of valid; resp0_valid two cycles after the handshake; data=8, zero=0, err=0.
- Contention:
  - First round: req0 and req1 both valid from reset, req0 {7,2,SUBU}, req1 {0,0x1234,LUI}; req0 granted first (data=5); req1 then returns 0x12340000.
  - Second round: both valid again; req0 granted, since last_owner=1.
- EQL: req1 {A=9, B=9, EQL} -> zero=1, data=0; then {9, 8, EQL} -> zero=0.
- Unsupported op: req0 op=5'h1F -> no EXEC cycle (alu_op stays IDLE_OP); resp0_valid one cycle after the handshake with err=1, data=0.
- Backpressure: resp0_ready low for 4 cycles -> resp0_valid and data held; req1_valid high throughout with req1_ready=0; req1 granted in the cycle after the resp0 handshake.
- Reset in EXEC: pulse rstn low mid-operation -> all valid/ready=0 immediately; no response after release; the next request is serviced normally.
